// File: rtl/uart_rx_if.sv
// Consumer-side bundle for uart_rx: held byte, status flags and the read acknowledge.
// The receiver uses the master modport; the consuming logic uses the slave modport.
interface uart_rx_if;
  logic       rd_uart;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  modport master (
    input  rd_uart,
    output rx_data, rx_valid, frame_err, parity_err, overrun
  );

  modport slave (
    output rd_uart,
    input  rx_data, rx_valid, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver with a one-byte holding register and overrun flag.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int unsigned OVS_DIV    = 651,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int unsigned CW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;

  generate
    if (PARITY_ODD > 1) begin : g_parity_odd_check
      $error("PARITY_ODD must be 0 or 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic          sync1, rx_s, rx_prev;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    os_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          stop_bit;
  logic          done;
  logic          break_wait;
`ifdef UART_RX_PARITY_EN
  logic          par_pend;
`endif

  logic [7:0]    rx_data_r;
  logic          rx_valid_r, frame_err_r, parity_err_r, overrun_r;

  assign bus.rx_data    = rx_data_r;
  assign bus.rx_valid   = rx_valid_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.parity_err = parity_err_r;
  assign bus.overrun    = overrun_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  assign tick = (tick_cnt == CW'(OVS_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      os_cnt       <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      stop_bit     <= 1'b1;
      done         <= 1'b0;
      break_wait   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_pend     <= 1'b0;
`endif
      rx_data_r    <= '0;
      rx_valid_r   <= 1'b0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      done <= 1'b0;

      case (state)
        IDLE: begin
          // A low stop bit means a break: ignore the line until it is seen high again.
          if (break_wait) begin
            if (rx_s) break_wait <= 1'b0;
          end else if (rx_prev && !rx_s) begin
            state  <= START;
            os_cnt <= '0;
          end
        end

        START: begin
          if (tick) begin
            if (os_cnt == 4'd7) begin
              if (!rx_s) begin
                state   <= DATA;
                os_cnt  <= '0;
                bit_idx <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (os_cnt == 4'd15) begin
              os_cnt  <= '0;
              shift   <= {rx_s, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (os_cnt == 4'd15) begin
              os_cnt   <= '0;
              par_pend <= rx_s ^ (^shift) ^ 1'(PARITY_ODD);
              state    <= STOP;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
`endif

        STOP: begin
          if (tick) begin
            if (os_cnt == 4'd15) begin
              os_cnt   <= '0;
              stop_bit <= rx_s;
              done     <= 1'b1;
              state    <= IDLE;
              if (!rx_s) break_wait <= 1'b1;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase

      // Completion takes priority over a plain read; a read in the same clk only suppresses overrun.
      if (done) begin
        rx_data_r   <= shift;
        frame_err_r <= ~stop_bit;
`ifdef UART_RX_PARITY_EN
        parity_err_r <= par_pend;
`endif
        rx_valid_r  <= 1'b1;
        if (rx_valid_r && !bus.rd_uart) begin
          overrun_r <= 1'b1;
        end else if (rx_valid_r && bus.rd_uart) begin
          overrun_r <= 1'b0;
        end
      end else if (bus.rd_uart && rx_valid_r) begin
        rx_valid_r <= 1'b0;
        overrun_r  <= 1'b0;
      end
    end
  end

endmodule
